piso_tx: RTL and testbench



---
 rtl/piso_tx_pkg.sv | 19 +
 rtl/piso_tx_tick_gen.sv | 34 +++
 rtl/piso_tx.sv | 126 ++++++++++++
 tb/tb_piso_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared types and constants for the framed PISO transmitter.
//   tx_state_e  - transmitter FSM states
//   LINE_IDLE   - serial line level between frames
//   START_BIT   - level driven during the start bit
//   STOP_BIT    - level driven during the stop bit
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/piso_tx_tick_gen.sv
// tick_gen: bit-period prescaler producing a one-cycle clock enable.
//   clk      in   system clock
//   clear    in   asynchronous active-high reset
//   restart  in   hold/return the count to 0 (synchronous)
//   tick     out  high in the last cycle of every DIV-cycle period
// The count runs 0..DIV-1; tick is decoded from the count so it lines up
// with the cycle in which the bit period ends. With DIV=1 tick is always high.
module tick_gen #(
  parameter int DIV = 65536
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TC);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out framed transmitter, MSB first.
//   clk       in   system clock
//   clear     in   asynchronous active-high reset
//   tx_data   in   word to send, sampled on accept
//   tx_valid  in   upstream has a word
//   tx_ready  out  idle and able to accept (decoded from state)
//   so        out  serial line (registered)
//   busy      out  frame in progress (registered)
//   done      out  one-cycle pulse after the last bit period (registered)
//
// state | meaning
// IDLE  | line idle, ready for a word, prescaler held at 0
// START | driving the start bit for one bit period
// DATA  | shifting out WIDTH data bits, MSB first
// STOP  | driving the stop bit for one bit period
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIV    = 65536,
  parameter int FRAMED = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  tx_state_e        state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [BCW-1:0]   bitcnt, bitcnt_nx;
  logic             so_nx, busy_nx, done_nx;
  logic             tick;
  logic             accept;
  logic             last_bit;

  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid && (state == IDLE);
  assign last_bit = (bitcnt == LAST_BIT);

  // Held in IDLE, so the count is already 0 on the accept edge and every
  // bit of the frame gets exactly DIV cycles.
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk     (clk),
    .clear   (clear),
    .restart (state == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = (FRAMED != 0) ? START : DATA;
      START: if (tick) state_nx = DATA;
      DATA:  if (tick && last_bit) state_nx = (FRAMED != 0) ? STOP : IDLE;
      STOP:  if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so the first
  // bit is on the line in the cycle right after the accept edge.
  always_comb begin
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    done_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_nx  = tx_data;
          bitcnt_nx = '0;
        end
      end
      START: bitcnt_nx = '0;
      DATA: begin
        if (tick) begin
          shreg_nx  = shreg << 1;
          bitcnt_nx = bitcnt + BCW'(1);
          if (last_bit && (FRAMED == 0)) done_nx = 1'b1;
        end
      end
      STOP: if (tick) done_nx = 1'b1;
      default: ;
    endcase

    unique case (state_nx)
      START:   so_nx = START_BIT;
      DATA:    so_nx = shreg_nx[WIDTH-1];
      STOP:    so_nx = STOP_BIT;
      default: so_nx = LINE_IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shreg  <= '0;
      bitcnt <= '0;
      so     <= LINE_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      shreg  <= shreg_nx;
      bitcnt <= bitcnt_nx;
      so     <= so_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx in three configurations
//   u_f : WIDTH=4 DIV=1 FRAMED=1
//   u_p : WIDTH=4 DIV=3 FRAMED=1
//   u_u : WIDTH=4 DIV=1 FRAMED=0
module tb_piso_tx;

  logic clk = 1'b0;
  logic clear;

  logic [3:0] d0, d1, d2;
  logic v0, v1, v2;
  logic ready0, ready1, ready2;
  logic so0, so1, so2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .DIV(1), .FRAMED(1)) u_f (
    .clk(clk), .clear(clear), .tx_data(d0), .tx_valid(v0),
    .tx_ready(ready0), .so(so0), .busy(busy0), .done(done0)
  );

  piso_tx #(.WIDTH(4), .DIV(3), .FRAMED(1)) u_p (
    .clk(clk), .clear(clear), .tx_data(d1), .tx_valid(v1),
    .tx_ready(ready1), .so(so1), .busy(busy1), .done(done1)
  );

  piso_tx #(.WIDTH(4), .DIV(1), .FRAMED(0)) u_u (
    .clk(clk), .clear(clear), .tx_data(d2), .tx_valid(v2),
    .tx_ready(ready2), .so(so2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp6;
    logic [3:0] exp4;
    bit seen_done;

    clear = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0;   d1 = '0;   d2 = '0;
    repeat (2) @(negedge clk);
    check("rst_so0", so0, 1'b0);
    check("rst_ready0", ready0, 1'b1);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_so1", so1, 1'b0);
    check("rst_so2", so2, 1'b0);
    clear = 1'b0;
    @(negedge clk);

    // single framed word, DIV=1: start, 1001, stop
    d0 = 4'b1001; v0 = 1'b1;
    @(posedge clk);
    exp6 = 6'b110010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) v0 = 1'b0;
      check("single_so", so0, exp6[5-k]);
      check("single_busy", busy0, 1'b1);
      check("single_done_low", done0, 1'b0);
    end
    @(negedge clk);
    check("single_done", done0, 1'b1);
    check("single_busy_end", busy0, 1'b0);
    check("single_ready_end", ready0, 1'b1);
    check("single_so_end", so0, 1'b0);
    @(negedge clk);
    check("single_done_once", done0, 1'b0);

    // prescaler DIV=3: each of 1,0,1,1,0,0 held 3 cycles, done at A+19
    d1 = 4'b0110; v1 = 1'b1;
    @(posedge clk);
    exp6 = 6'b101100;
    for (int b = 0; b < 6; b++) begin
      for (int r = 0; r < 3; r++) begin
        @(negedge clk);
        if (b == 0 && r == 0) v1 = 1'b0;
        check("div3_so", so1, exp6[5-b]);
        check("div3_done_low", done1, 1'b0);
      end
    end
    @(negedge clk);
    check("div3_done", done1, 1'b1);
    check("div3_busy_end", busy1, 1'b0);

    // unframed: 1011 on A+1..A+4, done on A+5
    d2 = 4'b1011; v2 = 1'b1;
    @(posedge clk);
    exp4 = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) v2 = 1'b0;
      check("unf_so", so2, exp4[3-k]);
      check("unf_busy", busy2, 1'b1);
    end
    @(negedge clk);
    check("unf_done", done2, 1'b1);
    check("unf_so_end", so2, 1'b0);
    check("unf_ready_end", ready2, 1'b1);

    // back-to-back with tx_valid held: A then 5
    @(negedge clk);
    d0 = 4'hA; v0 = 1'b1;
    @(posedge clk);
    exp6 = 6'b110100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) d0 = 4'h5;
      check("b2b_f1_so", so0, exp6[5-k]);
    end
    @(negedge clk);
    check("b2b_gap_done", done0, 1'b1);
    check("b2b_gap_so", so0, 1'b0);
    check("b2b_gap_ready", ready0, 1'b1);
    exp6 = 6'b101010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) v0 = 1'b0;
      check("b2b_f2_so", so0, exp6[5-k]);
      check("b2b_f2_busy", busy0, 1'b1);
    end
    @(negedge clk);
    check("b2b_f2_done", done0, 1'b1);
    @(negedge clk);

    // data toggled while busy is ignored; valid dropped before done
    d0 = 4'b0011; v0 = 1'b1;
    @(posedge clk);
    exp6 = 6'b100110;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      d0 = d0 ^ 4'hF;
      if (k == 5) v0 = 1'b0;
      check("hs_so", so0, exp6[5-k]);
      check("hs_ready_low", ready0, 1'b0);
    end
    @(negedge clk);
    check("hs_done", done0, 1'b1);
    @(negedge clk);
    check("hs_no_reaccept_busy", busy0, 1'b0);
    check("hs_no_reaccept_so", so0, 1'b0);
    check("hs_ready", ready0, 1'b1);

    // asynchronous clear mid-frame, off the clock edge
    d1 = 4'b0110; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    @(posedge clk);
    #3;
    check("rst_mid_pre_so", so1, 1'b1);
    check("rst_mid_pre_busy", busy1, 1'b1);
    clear = 1'b1;
    #1;
    check("rst_mid_so", so1, 1'b0);
    check("rst_mid_busy", busy1, 1'b0);
    check("rst_mid_ready", ready1, 1'b1);
    @(negedge clk);
    clear = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done1) seen_done = 1'b1;
    end
    check("rst_mid_no_done", seen_done, 1'b0);
    check("rst_mid_idle", busy1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
